// File: rtl/argmax_classifier_if.sv
// Tile-to-classifier and classifier-to-host signal bundle for argmax_classifier.
// Margin outputs exist only when ARGMAX_MARGIN_EN is defined.
interface argmax_classifier_if #(
    parameter int unsigned OUTPUT_SZ = 10,
    parameter int unsigned DATA_W    = 32
);
    localparam int unsigned IDX_W = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;

    logic                             done;
    logic [OUTPUT_SZ-1:0][DATA_W-1:0] result;
    logic                             class_valid;
    logic                             class_ready;
    logic [IDX_W-1:0]                 class_idx;
    logic [DATA_W-1:0]                class_score;
    logic                             busy;
    logic                             overrun;
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0]                second_score;
    logic [DATA_W:0]                  margin;
`endif

    // Tile / host side
    modport master (
        output done, result, class_ready,
        input  class_valid, class_idx, class_score, busy, overrun
`ifdef ARGMAX_MARGIN_EN
        , input second_score, margin
`endif
    );

    // Classifier side
    modport slave (
        input  done, result, class_ready,
        output class_valid, class_idx, class_score, busy, overrun
`ifdef ARGMAX_MARGIN_EN
        , output second_score, margin
`endif
    );
endinterface

// File: rtl/argmax_classifier.sv
// Captures a score vector on done, scans it one element per cycle for the signed maximum,
// and holds the winner on a valid/ready handshake. Optional runner-up/margin: ARGMAX_MARGIN_EN.
module argmax_classifier #(
    parameter int unsigned OUTPUT_SZ = 10,
    parameter int unsigned DATA_W    = 32
) (
    input logic                clk,
    input logic                rst_n,
    argmax_classifier_if.slave bus
);
    localparam int unsigned IDX_W = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t                           state_q, state_d;
    logic [OUTPUT_SZ-1:0][DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0]                best_val_q, best_val_d;
    logic [IDX_W-1:0]                 best_idx_q, best_idx_d;
    logic [IDX_W-1:0]                 scan_idx_q, scan_idx_d;
    logic                             overrun_q, overrun_d;
    logic [DATA_W-1:0]                elem;
`ifdef ARGMAX_MARGIN_EN
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    logic [DATA_W-1:0]                second_val_q, second_val_d;
`endif

    // Element under scan; written as a compare-mux so OUTPUT_SZ == 1 never indexes out of range.
    always_comb begin
        elem = '0;
        for (int unsigned i = 0; i < OUTPUT_SZ; i++) begin
            if (scan_idx_q == IDX_W'(i)) begin
                elem = res_q[i];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        res_d      = res_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        scan_idx_d = scan_idx_q;
        overrun_d  = 1'b0;
`ifdef ARGMAX_MARGIN_EN
        second_val_d = second_val_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.done) begin
                    res_d      = bus.result;
                    best_val_d = bus.result[0];
                    best_idx_d = '0;
                    scan_idx_d = IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                    second_val_d = MOST_NEG;
`endif
                    state_d    = (OUTPUT_SZ == 1) ? S_HOLD : S_SCAN;
                end
            end
            S_SCAN: begin
                overrun_d = bus.done;
                // Strictly greater keeps the lowest index on ties.
                if ($signed(elem) > $signed(best_val_q)) begin
                    best_val_d = elem;
                    best_idx_d = scan_idx_q;
`ifdef ARGMAX_MARGIN_EN
                    second_val_d = best_val_q;
                end else if ($signed(elem) > $signed(second_val_q)) begin
                    second_val_d = elem;
`endif
                end
                scan_idx_d = scan_idx_q + 1'b1;
                if (scan_idx_q == IDX_W'(OUTPUT_SZ - 1)) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                overrun_d = bus.done;
                if (bus.class_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            res_q      <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            scan_idx_q <= '0;
            overrun_q  <= 1'b0;
`ifdef ARGMAX_MARGIN_EN
            second_val_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            res_q      <= res_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            scan_idx_q <= scan_idx_d;
            overrun_q  <= overrun_d;
`ifdef ARGMAX_MARGIN_EN
            second_val_q <= second_val_d;
`endif
        end
    end

    assign bus.class_valid = (state_q == S_HOLD);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.class_idx   = best_idx_q;
    assign bus.class_score = best_val_q;
    assign bus.overrun     = overrun_q;
`ifdef ARGMAX_MARGIN_EN
    assign bus.second_score = second_val_q;
    // Sign-extend both operands one bit so the difference cannot overflow.
    assign bus.margin = {best_val_q[DATA_W-1], best_val_q} - {second_val_q[DATA_W-1], second_val_q};
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// Randomized scoreboard bench for argmax_classifier: the driver pushes reference results,
// an independent monitor pops and compares whenever class_valid is presented.
module tb_argmax_classifier;
    localparam int unsigned OUTPUT_SZ = 10;
    localparam int unsigned DATA_W    = 32;

    typedef logic [DATA_W-1:0] word_t;
    typedef struct {
        longint      idx;
        longint      score;
        longint      second;
        longint      margin;
        int unsigned de;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc   = 0;

    exp_t        sb[$];
    int unsigned ovr_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    argmax_classifier_if #(.OUTPUT_SZ(OUTPUT_SZ), .DATA_W(DATA_W)) bus ();

    argmax_classifier #(.OUTPUT_SZ(OUTPUT_SZ), .DATA_W(DATA_W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed maximum, lowest index holding it, runner-up = max of the remaining multiset.
    function automatic exp_t model(input word_t s[OUTPUT_SZ], input int unsigned de);
        exp_t   e;
        longint v[OUTPUT_SZ];
        longint mx;
        longint sec;
        int     wi;
        for (int i = 0; i < OUTPUT_SZ; i++) v[i] = longint'($signed(s[i]));
        mx = v[0];
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        wi = -1;
        foreach (v[i]) if (wi < 0 && v[i] == mx) wi = i;
        sec = -(longint'(1) <<< (DATA_W - 1));
        foreach (v[i]) if (i != wi && v[i] > sec) sec = v[i];
        e.idx    = wi;
        e.score  = mx;
        e.second = sec;
        e.margin = mx - sec;
        e.de     = de;
        return e;
    endfunction

    task automatic drive_vec(input word_t s[OUTPUT_SZ]);
        for (int i = 0; i < OUTPUT_SZ; i++) bus.result[i] = s[i];
    endtask

    task automatic scramble();
        for (int i = 0; i < OUTPUT_SZ; i++) bus.result[i] = $urandom;
    endtask

    // drop_at: extra done this many edges after capture (0 = none).
    task automatic run_txn(input word_t s[OUTPUT_SZ], input int unsigned drop_at,
                           input int unsigned hold, input bit accept_done);
        bit seen;
        @(posedge clk); #1;
        drive_vec(s);
        bus.done = 1'b1;
        sb.push_back(model(s, cyc + 1));
        @(posedge clk); #1;
        bus.done = 1'b0;
        scramble();
        if (drop_at > 0) begin
            repeat (drop_at - 1) @(posedge clk);
            #1;
            bus.done = 1'b1;
            scramble();
            ovr_q.push_back(cyc + 1);
            @(posedge clk); #1;
            bus.done = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            seen = bus.class_valid;
        end
        chk("valid_timeout", seen, 1);
        repeat (hold + 1) @(posedge clk);
        #1;
        bus.class_ready = 1'b1;
        if (accept_done) begin
            bus.done = 1'b1;
            ovr_q.push_back(cyc + 1);
        end
        @(posedge clk); #1;
        bus.class_ready = 1'b0;
        bus.done        = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_valid"}, bus.class_valid, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_idx"}, bus.class_idx, 0);
        chk({tag, "_score"}, bus.class_score, 0);
        chk({tag, "_overrun"}, bus.overrun, 0);
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_second"}, bus.second_score, 0);
        chk({tag, "_margin"}, bus.margin, 0);
`endif
    endtask

    // Monitor: pops an expectation on each newly presented result and checks it every held cycle.
    exp_t cur;
    bit   in_hold     = 1'b0;
    bit   acc_pending = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            bit e;
            if (acc_pending) begin
                chk("valid_fall", bus.class_valid, 0);
                chk("busy_after_accept", bus.busy, 0);
                in_hold     = 1'b0;
                acc_pending = 1'b0;
            end else if (bus.class_valid) begin
                if (!in_hold) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_result: got class_valid, required no pending result");
                        cur = '{default: 0};
                    end else begin
                        cur = sb.pop_front();
                        chk("latency", longint'(cyc) - longint'(cur.de), OUTPUT_SZ - 1);
                    end
                    in_hold = 1'b1;
                end
                chk("class_idx", bus.class_idx, cur.idx);
                chk("class_score", longint'($signed(bus.class_score)), cur.score);
                chk("busy_hold", bus.busy, 1);
`ifdef ARGMAX_MARGIN_EN
                chk("second_score", longint'($signed(bus.second_score)), cur.second);
                chk("margin", longint'($signed(bus.margin)), cur.margin);
`endif
                if (bus.class_ready) acc_pending = 1'b1;
            end
            e = (ovr_q.size() > 0) && (ovr_q[0] == cyc);
            if (e) void'(ovr_q.pop_front());
            if (e || bus.overrun) chk("overrun", bus.overrun, e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        word_t v[OUTPUT_SZ];
        bus.done        = 1'b0;
        bus.class_ready = 1'b0;
        bus.result      = '0;

        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic argmax
        v = '{5, 1, 3, 9, 2, 0, 7, 4, 8, 6};
        run_txn(v, 0, 0, 1'b0);

        // Ties and negative values
        foreach (v[i]) v[i] = 32'hFFFF_FFFC;
        v[2] = 100;
        v[7] = 100;
        run_txn(v, 0, 0, 1'b0);
        foreach (v[i]) v[i] = 32'h8000_0000;
        run_txn(v, 0, 1, 1'b0);

        // Margin with equal top two
        foreach (v[i]) v[i] = 0;
        v[0] = 50;
        v[1] = 50;
        run_txn(v, 0, 0, 1'b0);

        // Backpressure: long hold
        foreach (v[i]) v[i] = $urandom;
        run_txn(v, 0, 20, 1'b0);

        // Overrun: done at edge 4 of the scan and in the accept cycle
        v = '{5, 1, 3, 9, 2, 0, 7, 4, 8, 6};
        run_txn(v, 4, 2, 1'b1);

        // Reset mid-scan, then a clean transaction
        @(posedge clk); #1;
        foreach (v[i]) v[i] = $urandom;
        drive_vec(v);
        bus.done = 1'b1;
        @(posedge clk); #1;
        bus.done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midscan_reset");
        @(negedge clk);
        rst_n = 1'b1;
        v = '{-3, 12, 12, -40, 7, 0, 11, 2, 12, 1};
        run_txn(v, 0, 0, 1'b0);

        // Randomized traffic
        for (int t = 0; t < 30; t++) begin
            int unsigned mode;
            mode = $urandom_range(0, 2);
            foreach (v[i]) begin
                case (mode)
                    0:       v[i] = $urandom;
                    1:       v[i] = word_t'($urandom_range(0, 6)) - 3;
                    default: begin
                        case ($urandom_range(0, 2))
                            0:       v[i] = 32'h7FFF_FFFF;
                            1:       v[i] = 32'h8000_0000;
                            default: v[i] = 0;
                        endcase
                    end
                endcase
            end
            run_txn(v, $urandom_range(0, 9) * $urandom_range(0, 1), $urandom_range(0, 4),
                    1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        chk("overrun_queue_drained", ovr_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/argmax_classifier.md
Name: argmax_classifier

Overview:
- Sits directly downstream of the two-layer inference tile. Consumes the tile's `done` pulse and its `OUTPUT_SZ` × 32-bit `result` vector.
- Captures the vector and scans it serially, one element per cycle, to find the winning class.
- Presents the class index and score on a valid/ready handshake to the host-side readout logic.

Parameters:
- OUTPUT_SZ, 10, number of output neurons (class scores); must be ≥ 1.
- DATA_W, 32, width of each score.
- IDX_W, $clog2(OUTPUT_SZ) (1 if OUTPUT_SZ == 1), width of the class index; derived, not overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- done  input  1  one-cycle pulse from the tile; result is valid in the same cycle.
- result  input  [OUTPUT_SZ-1:0][DATA_W-1:0]  class scores from the tile.
- class_valid  output  1  class_idx/class_score hold a finished result.
- class_ready  input  1  consumer accepts the result when high with class_valid.
- class_idx  output  IDX_W  index of the maximum score.
- class_score  output  DATA_W  maximum score value.
- busy  output  1  high in S_SCAN or S_HOLD.
- overrun  output  1  one-cycle pulse: a done pulse was dropped.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = S_IDLE.
  - class_valid, busy, overrun = 0.
  - class_idx, class_score = 0.
  - Score register array and scan counter = 0.
  - Applies at any time, including mid-scan or mid-hold; an in-flight result is discarded.
- States: S_IDLE, S_SCAN, S_HOLD.
- S_IDLE, on a clk edge with done = 1:
  - Register all of result into res_reg.
  - Set best_val = result[0], best_idx = 0, scan_idx = 1.
  - Next state is S_SCAN, or S_HOLD directly if OUTPUT_SZ == 1.
  - With done = 0, stay in S_IDLE.
- S_SCAN, each edge:
  - If res_reg[scan_idx] > best_val, load best_val and best_idx from that element.
  - Increment scan_idx.
  - Move to S_HOLD on the edge that processes scan_idx == OUTPUT_SZ-1.
- Comparison rules:
  - Signed two's-complement comparison.
  - Strictly greater, so on ties the lowest index wins.
- Latency:
  - class_valid rises OUTPUT_SZ-1 edges after the edge that sampled done (9 edges at the default).
  - S_SCAN lasts OUTPUT_SZ-1 cycles.
- S_HOLD:
  - class_valid = 1.
  - class_idx = best_idx and class_score = best_val, held stable until accepted.
  - On an edge with class_ready = 1, return to S_IDLE; class_valid falls the next cycle.
  - class_ready is ignored outside S_HOLD.
- Busy and back-to-back rules:
  - busy = (state != S_IDLE), decoded from the state register.
  - A done sampled in S_SCAN or S_HOLD is dropped; overrun pulses high for exactly one cycle after that edge. This includes a done in the same cycle as the S_HOLD accept.
  - res_reg, best_val and best_idx are not disturbed by a dropped done.
- No combinational path from any input to any output.

Optional Feature:
- Macro: ARGMAX_MARGIN_EN.
- When defined, add ports:
  - second_score  output  DATA_W: runner-up score.
  - margin  output  DATA_W+1: class_score − second_score, signed, computed at full width with no overflow.
- Second-best tracking:
  - At capture, second_val = most-negative DATA_W value.
  - In S_SCAN, if new > best_val: second_val = best_val, and best is updated as above.
  - Else if new > second_val: second_val = new.
  - Equal-to-best values update second_val (best stays unchanged).
- second_score and margin are valid under class_valid and reset to 0.
- For OUTPUT_SZ == 1, second_score = most-negative value.
- When not defined: the ports and the second_val register do not exist, and behaviour is otherwise identical.

Test Plan:
- Basic argmax:
  - Stimulus: result = {0..9} = 5,1,3,9,2,0,7,4,8,6; done pulse at edge 0; class_ready = 1.
  - Required: class_valid rises after edge 9 with class_idx = 3, class_score = 9; falls the next cycle.
- Tie and negative values:
  - Stimulus: all scores = −4 except [2] = [7] = 100.
  - Required: class_idx = 2, class_score = 100. Also all scores = 0x80000000 → class_idx = 0.
- Hold/backpressure:
  - Stimulus: hold class_ready = 0 for 20 cycles after valid, then raise it.
  - Required: outputs stay stable for all 20 cycles, busy = 1 throughout, and one accept returns to S_IDLE.
- Overrun:
  - Stimulus: done pulses at edge 0 and edge 4, plus a done in the accept cycle.
  - Required: overrun pulses once for each dropped done; the result still reflects the edge-0 data.
- Reset mid-scan:
  - Stimulus: drive rst_n low at edge 5.
  - Required: class_valid, busy, class_idx, class_score = 0 immediately. A new done afterwards gives the correct result with latency 9.
- ARGMAX_MARGIN_EN:
  - Stimulus: scores 5,1,3,9,2,0,7,4,8,6.
  - Required: second_score = 8, margin = 1. With scores [0] = [1] = 50, rest 0: class_idx = 0, second_score = 50, margin = 0.
